seg_scan_driver: RTL and testbench

//   Downstream display stage for the 4-bit adder/overflow datapath. Latches a 16-bit

---
 rtl/seg_scan_driver.sv | 93 +++++++++
 tb/tb_seg_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Latches a 16-bit hex value plus overflow flag and time-multiplexes it onto a
// 4-digit common-anode seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        oflow_in,
    input  logic        clr_oflow,
    output logic [6:0]  seg_L,
    output logic [3:0]  an_L,
    output logic        dp_L,
    output logic        oflow_led
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]      shadow;
    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       idx;
    logic [3:0]       nib;
    logic [6:0]       seg_nxt;
    logic             blank;

    always_comb begin
        nib = shadow[{idx, 2'b00} +: 4];
        case (nib)
            4'h0: seg_nxt = 7'b1000000;
            4'h1: seg_nxt = 7'b1111001;
            4'h2: seg_nxt = 7'b0100100;
            4'h3: seg_nxt = 7'b0110000;
            4'h4: seg_nxt = 7'b0011001;
            4'h5: seg_nxt = 7'b0010010;
            4'h6: seg_nxt = 7'b0000010;
            4'h7: seg_nxt = 7'b1111000;
            4'h8: seg_nxt = 7'b0000000;
            4'h9: seg_nxt = 7'b0010000;
            4'hA: seg_nxt = 7'b0001000;
            4'hB: seg_nxt = 7'b0000011;
            4'hC: seg_nxt = 7'b1000110;
            4'hD: seg_nxt = 7'b0100001;
            4'hE: seg_nxt = 7'b0000110;
            default: seg_nxt = 7'b0001110;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit goes dark only when it and every digit to its left is zero.
    always_comb begin
        case (idx)
            2'd1:    blank = (shadow[15:4] == 12'h000);
            2'd2:    blank = (shadow[15:8] == 8'h00);
            2'd3:    blank = (shadow[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            slot_cnt  <= '0;
            idx       <= 2'd0;
            oflow_led <= 1'b0;
            an_L      <= 4'b1111;
            seg_L     <= 7'b1111111;
            dp_L      <= 1'b1;
        end else begin
            if (load)
                shadow <= value;
            // A fresh overflow beats a simultaneous clear.
            if (load && oflow_in)
                oflow_led <= 1'b1;
            else if (clr_oflow)
                oflow_led <= 1'b0;
            if (slot_cnt == CNT_MAX) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            an_L  <= ~(4'b0001 << idx);
            seg_L <= blank ? 7'b1111111 : seg_nxt;
            dp_L  <= ~((idx == 2'd0) && oflow_led);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (REFRESH_DIV=4): stimulus pushes expected
// digit slots, a negedge monitor pops one entry at every new digit slot.
module tb_seg_scan_driver;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        oflow_in = 1'b0;
    logic        clr_oflow = 1'b0;
    logic [6:0]  seg_L;
    logic [3:0]  an_L;
    logic        dp_L;
    logic        oflow_led;

    seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .oflow_in(oflow_in),
        .clr_oflow(clr_oflow), .seg_L(seg_L), .an_L(an_L), .dp_L(dp_L),
        .oflow_led(oflow_led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
        logic [15:0] upper;
        upper = v >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && upper == 16'h0000)
            return 7'b1111111;
`endif
        return hex_tbl[upper[3:0]];
    endfunction

    // Monitor: one-hot check, slot length, and scoreboard pop at each slot start.
    logic [3:0] prev_an = 4'hF;
    int         slot_len = 0;
    logic       rst_q = 1'b1;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !rst_q) begin
            tests++;
            if ($countones(~an_L) != 1) begin
                fails++;
                $display("FAIL onehot: an_L=%b required exactly one low bit", an_L);
            end
        end
        if (an_L !== prev_an && an_L !== 4'hF) begin
            if (prev_an !== 4'hF) begin
                tests++;
                if (slot_len != DIV) begin
                    fails++;
                    $display("FAIL slot_len: got %0d required %0d", slot_len, DIV);
                end
            end
            slot_len = 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (an_L !== e.an || seg_L !== e.seg || dp_L !== e.dp) begin
                    fails++;
                    $display("FAIL slot: got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                             an_L, seg_L, dp_L, e.an, e.seg, e.dp);
                end
            end
        end else begin
            slot_len++;
        end
        prev_an = an_L;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic o, input logic c);
        load = 1'b1; value = v; oflow_in = o; clr_oflow = c;
        @(posedge clk); #1;
        load = 1'b0; oflow_in = 1'b0; clr_oflow = 1'b0;
    endtask

    task automatic do_clr();
        clr_oflow = 1'b1;
        @(posedge clk); #1;
        clr_oflow = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] tgt);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (an_L === tgt) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_an: an_L=%b never reached required %b", an_L, tgt);
        end
        @(posedge clk); #1;
    endtask

    // Sync to the digit-3 slot, then expect a full scan starting at digit 0.
    task automatic scan(input logic [15:0] v, input logic ofl);
        bit drained = 1'b0;
        exp_t e;
        wait_an(4'b0111);
        for (int k = 0; k < 4; k++) begin
            e.an  = ~(4'b0001 << k);
            e.seg = exp_seg(v, k);
            e.dp  = !(k == 0 && ofl);
            exp_q.push_back(e);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin drained = 1'b1; break; end
        end
        #1;
        tests++;
        if (!drained) begin
            fails++;
            $display("FAIL drain: %0d slots left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [15:0] vecs [8] = '{16'h0005, 16'h0000, 16'h0105, 16'h4567,
                              16'h89AB, 16'hCDEF, 16'h1200, 16'hFFFF};

    initial begin
        // 1. reset held, then release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {12'h0, an_L}, 16'h000F);
        chk("rst_seg", {9'h0, seg_L}, 16'h007F);
        chk("rst_dp", {15'h0, dp_L}, 16'h0001);
        chk("rst_oflow", {15'h0, oflow_led}, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_an", {12'h0, an_L}, 16'h000E);
        chk("first_seg", {9'h0, seg_L}, 16'h0040);

        // 2. basic decode
        do_load(16'h3A0F, 1'b0, 1'b0);
        scan(16'h3A0F, 1'b0);

        // 3. sticky overflow
        do_load(16'h1234, 1'b1, 1'b0);
        chk("oflow_set", {15'h0, oflow_led}, 16'h0001);
        scan(16'h1234, 1'b1);
        do_clr();
        chk("oflow_clr", {15'h0, oflow_led}, 16'h0000);
        oflow_in = 1'b1;
        @(posedge clk); #1;
        oflow_in = 1'b0;
        chk("oflow_noload", {15'h0, oflow_led}, 16'h0000);
        do_load(16'h5678, 1'b1, 1'b1);
        chk("oflow_setwins", {15'h0, oflow_led}, 16'h0001);
        scan(16'h5678, 1'b1);
        do_clr();

        // 4. adder sum 9+8 with overflow
        do_load(16'h0001, 1'b1, 1'b0);
        scan(16'h0001, 1'b1);
        do_clr();
        chk("oflow_clr2", {15'h0, oflow_led}, 16'h0000);

        // directed values covering every hex glyph and blanking edge cases
        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i], 1'b0, 1'b0);
            scan(vecs[i], 1'b0);
        end

        // 5. reset during digit-2 slot with a competing load
        do_load(16'h9876, 1'b1, 1'b0);
        wait_an(4'b1011);
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; oflow_in = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_an", {12'h0, an_L}, 16'h000F);
        chk("mid_rst_seg", {9'h0, seg_L}, 16'h007F);
        chk("mid_rst_dp", {15'h0, dp_L}, 16'h0001);
        chk("mid_rst_oflow", {15'h0, oflow_led}, 16'h0000);
        rst = 1'b0; load = 1'b0; oflow_in = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_an0", {12'h0, an_L}, 16'h000E);
        chk("mid_rst_seg0", {9'h0, seg_L}, 16'h0040);
        scan(16'h0000, 1'b0);

        repeat (8) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
